// File: rtl/feed_scheduler_if.sv
// Feed scheduler bus: BCD time digits, slot programming, requests and dispenser status.
interface feed_scheduler_if;
  logic        i_sec_tick;
  logic [3:0]  i_chour2;
  logic [3:0]  i_chour1;
  logic [3:0]  i_cminute2;
  logic [3:0]  i_cminute1;
  logic [3:0]  i_csecond2;
  logic [3:0]  i_csecond1;
  logic        i_wr_en;
  logic [1:0]  i_wr_slot;
  logic        i_wr_valid;
  logic [15:0] i_wr_time;
  logic        i_manual_feed;
  logic        i_inhibit;
  logic        o_motor;
  logic        o_done;
  logic        o_missed;
  logic [3:0]  o_feed_count;

  modport slave (
    input  i_sec_tick, i_chour2, i_chour1, i_cminute2, i_cminute1, i_csecond2, i_csecond1,
    input  i_wr_en, i_wr_slot, i_wr_valid, i_wr_time, i_manual_feed, i_inhibit,
    output o_motor, o_done, o_missed, o_feed_count
  );

  modport master (
    output i_sec_tick, i_chour2, i_chour1, i_cminute2, i_cminute1, i_csecond2, i_csecond1,
    output i_wr_en, i_wr_slot, i_wr_valid, i_wr_time, i_manual_feed, i_inhibit,
    input  o_motor, o_done, o_missed, o_feed_count
  );
endinterface

// File: rtl/feed_scheduler.sv
// Four-slot feed-time scheduler driving the dispenser motor, with one queued request.
// Optional daily feed counter built only when FEED_LOG_EN is defined.
module feed_scheduler #(
  parameter int unsigned DISPENSE_SECS = 5
) (
  input  logic           i_clk,
  input  logic           i_reset,
  feed_scheduler_if.slave bus
);
  localparam int unsigned SLOTS = 4;
  localparam int unsigned CW    = 8;
  localparam int unsigned TW    = 16;
  localparam int unsigned FCW   = 4;
  localparam logic [CW-1:0] LOAD = CW'(DISPENSE_SECS);

  typedef enum logic {ST_IDLE, ST_DISPENSE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SLOTS-1:0] r_slot_valid;
  logic [TW-1:0]   r_slot_time [SLOTS];
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic            r_pending;
  logic            w_pending_next;
  logic            r_motor;
  logic            r_done;
  logic            r_missed;
  logic            w_done;
  logic            w_missed;
  logic [TW-1:0]   w_now_hm;
  logic            w_sec_zero;
  logic [SLOTS-1:0] w_hit;
  logic            w_match;
  logic            w_req;
  logic            w_accept;
  logic            w_end_tick;

  assign w_now_hm   = {bus.i_chour2, bus.i_chour1, bus.i_cminute2, bus.i_cminute1};
  assign w_sec_zero = (bus.i_csecond2 == 4'd0) && (bus.i_csecond1 == 4'd0);

  // Slot storage; a write becomes visible to the matcher on the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slot_valid <= '0;
      for (int i = 0; i < SLOTS; i++) r_slot_time[i] <= '0;
    end else if (bus.i_wr_en) begin
      r_slot_valid[bus.i_wr_slot] <= bus.i_wr_valid;
      r_slot_time[bus.i_wr_slot]  <= bus.i_wr_time;
    end
  end

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < SLOTS; i++) w_hit[i] = r_slot_valid[i] && (r_slot_time[i] == w_now_hm);
  end

  // Seconds == 00 is true for a single tick, so each slot fires at most once per day.
  assign w_match    = bus.i_sec_tick && w_sec_zero && (|w_hit);
  assign w_req      = w_match || bus.i_manual_feed;
  assign w_accept   = w_req && !bus.i_inhibit;
  assign w_end_tick = bus.i_sec_tick && (r_count == CW'(1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_pending <= 1'b0;
      r_motor   <= 1'b0;
      r_done    <= 1'b0;
      r_missed  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_count   <= w_count_next;
      r_pending <= w_pending_next;
      r_motor   <= (w_next == ST_DISPENSE);
      r_done    <= w_done;
      r_missed  <= w_missed;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_count_next   = r_count;
    w_pending_next = r_pending;
    w_done         = 1'b0;
    w_missed       = w_req && bus.i_inhibit;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next       = ST_DISPENSE;
          w_count_next = LOAD;
        end
      end
      ST_DISPENSE: begin
        if (w_end_tick) begin
          w_done = 1'b1;
          // A request on the ending tick is served immediately if nothing is queued ahead of it.
          if (r_pending || w_accept) begin
            w_count_next   = LOAD;
            w_pending_next = r_pending && w_accept;
          end else begin
            w_next = ST_IDLE;
          end
        end else begin
          if (bus.i_sec_tick) w_count_next = r_count - CW'(1);
          if (w_accept) begin
            if (r_pending) w_missed = 1'b1;
            else           w_pending_next = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.o_motor  = r_motor;
  assign bus.o_done   = r_done;
  assign bus.o_missed = r_missed;

`ifdef FEED_LOG_EN
  logic [FCW-1:0] r_feed_count;
  logic           w_midnight;

  assign w_midnight = bus.i_sec_tick && w_sec_zero && (w_now_hm == '0);

  // Daily completion count, saturating; the midnight tick restarts it (counting a coincident Done).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_feed_count <= '0;
    end else if (w_midnight) begin
      r_feed_count <= w_done ? FCW'(1) : '0;
    end else if (w_done && (r_feed_count != '1)) begin
      r_feed_count <= r_feed_count + FCW'(1);
    end
  end

  assign bus.o_feed_count = r_feed_count;
`else
  assign bus.o_feed_count = '0;
`endif

endmodule

// File: doc/feed_scheduler.md
# feed_scheduler

Programmable feed-time scheduler for the automatic pet feeder. Sits directly downstream of the 24 h BCD clock. It compares the current time digits against four user-programmed feed slots and drives the dispenser motor for a fixed number of seconds on each match or manual request. It also queues one overlapping request and reports completions and dropped feeds.

## Interface
- DISPENSE_SECS, 5: motor-on time in seconds; legal range 1..255 (8-bit counter)
- Clk  in  1  system clock; all logic on posedge
- Reset  in  1  synchronous, active-high reset
- SecTick  in  1  one-cycle strobe per second, aligned with clock-digit updates
- chour2, chour1, cminute2, cminute1, csecond2, csecond1  in  4 each  current time, BCD digits
- WrEn  in  1  slot write strobe
- WrSlot  in  2  slot index 0..3
- WrValid  in  1  slot enable bit written with the slot
- WrTime  in  16  slot time {hour2, hour1, minute2, minute1}, BCD
- ManualFeed  in  1  one-cycle manual feed request
- Inhibit  in  1  hopper-empty / feeding-disabled level
- Motor  out  1  dispenser motor drive
- Done  out  1  one-cycle pulse at the end of each dispense
- Missed  out  1  one-cycle pulse when a request is dropped
- FeedCount  out  4  feeds completed today (see Configuration)

## Operation
- Reset: all slots invalid with time 0000; state IDLE; Motor, Done, Missed = 0; pending flag = 0; counter = 0; FeedCount = 0.
- Slot write: on WrEn, slot[WrSlot] <= {WrValid, WrTime}. The value is visible to the matcher from the next cycle.
- Match is evaluated only in a SecTick cycle. A match is any valid slot whose four digits equal chour2..cminute1, with csecond2 = 0 and csecond1 = 0.
  - Several slots matching at once produce a single request.
  - Each slot fires at most once per day: seconds = 00 holds for only one tick.
- Request = match OR ManualFeed. Both in the same cycle produce a single request.
- Inhibit high when a request arrives: the request is dropped and Missed pulses. A dispense already running is unaffected by Inhibit.
- FSM:
  - IDLE: on a request, go to DISPENSE and load counter = DISPENSE_SECS.
  - DISPENSE: Motor = 1. Each SecTick decrements the counter.
    - On a SecTick with counter = 1, the dispense ends and Done pulses.
    - If pending = 1: reload the counter, clear pending, stay in DISPENSE.
    - Otherwise: go to IDLE.
  - A request arriving during DISPENSE sets pending.
  - A request arriving while pending is already 1 is dropped and Missed pulses.
  - A request in the same cycle as the ending tick counts as pending and is served next.
- Counter arithmetic is 8-bit unsigned. It never underflows, because the end condition is checked at 1.

## Timing
- Request in cycle T (IDLE): Motor = 1 from the edge ending T (registered output).
- Motor stays high for exactly DISPENSE_SECS SecTicks after entry; the entry-cycle tick is not counted.
- Done and Missed are registered. Each is high for exactly one cycle, the cycle after its cause.
- Back-to-back dispenses (pending served): Motor stays continuously high and Done pulses once per dispense.
- Reset asserted mid-dispense: Motor = 0 on the next edge; slots and pending are cleared.
- A slot rewrite during DISPENSE does not affect the running dispense.

## Configuration
- FEED_LOG_EN defined:
  - FeedCount increments on each Done and saturates at 15.
  - FeedCount clears on the SecTick at which time = 00:00:00.
  - If Done and the midnight clear fall in the same cycle, the result is 1.
- FEED_LOG_EN undefined: FeedCount is tied to 0 and no counter logic is built.

## Test plan
- Slot0 = 0730 valid, DISPENSE_SECS = 5, clock 07:29:58 ticking: Motor rises the cycle after the 07:30:00 tick, is high for 5 ticks, Done pulses once.
- Slot1 = 1200 written with WrValid = 0, time passes 12:00:00: no Motor and no Missed; then rewrite it valid and pass 12:00:00 again: one dispense.
- ManualFeed during dispense, then a second ManualFeed: first sets pending and yields a continuous 10-tick Motor with 2 Done pulses; second produces Missed.
- Inhibit = 1 at a slot match: Motor stays 0 and Missed pulses once. Inhibit raised mid-dispense: Motor runs to completion.
- Reset asserted in the 3rd second of a dispense: Motor 0 next cycle, all outputs at reset values, previously valid slots no longer fire.
- FEED_LOG_EN: 16 manual feeds give FeedCount = 15; the 00:00:00 tick clears it to 0. Without the macro, FeedCount stays 0 throughout.
